// File: rtl/axi4s_vid_out_formatter.sv
// Video output formatter: aligns a first-word-fall-through pixel FIFO to VTG timing
// and produces registered native video with lock and underflow status.
module axi4s_vid_out_formatter (
    input  logic        VID_OUT_CLK,
    input  logic        VID_RESET,
    input  logic        VID_CE,
    input  logic [26:0] FIFO_RD_DATA,
    input  logic        FIFO_EMPTY,
    output logic        FIFO_RD_EN,
    input  logic        VTG_ACTIVE_VIDEO,
    input  logic        VTG_VBLANK,
    input  logic        VTG_HBLANK,
    input  logic        VTG_VSYNC,
    input  logic        VTG_HSYNC,
    input  logic        VTG_FIELD_ID,
    output logic        VID_ACTIVE_VIDEO,
    output logic        VID_VBLANK,
    output logic        VID_HBLANK,
    output logic        VID_VSYNC,
    output logic        VID_HSYNC,
    output logic        VID_FIELD_ID,
    output logic [23:0] VID_DATA,
    output logic        LOCKED,
    output logic        UNDERFLOW
);

    typedef enum logic [1:0] {
        ST_SYNC_SOF   = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_RUN        = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        de_q;
    logic        vb_q;
    logic        flag_q;
    logic        flag_d;
    logic [5:0]  s1_timing_q;
    logic [23:0] s1_data_q;
    logic [5:0]  s2_timing_q;
    logic [23:0] s2_data_q;
    logic        locked_q;
    logic        underflow_q;

    logic        head_sof_s;
    logic        vb_s;
    logic        vb_rise_s;
    logic        tde_rise_s;
    logic        frame_start_s;
    logic        pop_s;
    logic        drive_s;
    logic        err_s;
    logic [5:0]  vtg_timing_s;

    assign head_sof_s    = FIFO_RD_DATA[25];
    assign vb_s          = VTG_VBLANK | VTG_VSYNC;
    assign vb_rise_s     = vb_s & ~vb_q;
    assign tde_rise_s    = VTG_ACTIVE_VIDEO & ~de_q;
    assign frame_start_s = tde_rise_s & flag_q;
    assign vtg_timing_s  = {VTG_ACTIVE_VIDEO, VTG_VBLANK, VTG_HBLANK,
                            VTG_VSYNC, VTG_HSYNC, VTG_FIELD_ID};

    // Vertical-blank flag: armed by the start of blanking, consumed by the first active pixel.
    always_comb begin
        flag_d = flag_q;
        if (vb_rise_s) begin
            flag_d = 1'b1;
        end else if (tde_rise_s) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    // Lock state machine: decides pops, pixel drive and error reporting for this cycle.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        drive_s = 1'b0;
        err_s   = 1'b0;
        case (state_q)
            ST_SYNC_SOF: begin
                // Purge until the head word opens a frame.
                if (!FIFO_EMPTY) begin
                    if (head_sof_s) begin
                        state_d = ST_WAIT_FRAME;
                    end else begin
                        pop_s = 1'b1;
                    end
                end else begin
                    state_d = ST_SYNC_SOF;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_start_s) begin
                    if (FIFO_EMPTY) begin
                        err_s   = 1'b1;
                        state_d = ST_SYNC_SOF;
                    end else if (head_sof_s) begin
                        pop_s   = 1'b1;
                        drive_s = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        err_s   = 1'b1;
                        state_d = ST_SYNC_SOF;
                    end
                end else begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_RUN: begin
                if (VTG_ACTIVE_VIDEO) begin
                    if (FIFO_EMPTY) begin
                        err_s   = 1'b1;
                        state_d = ST_SYNC_SOF;
                    end else if (frame_start_s && !head_sof_s) begin
                        err_s   = 1'b1;
                        state_d = ST_SYNC_SOF;
                    end else if (head_sof_s && !frame_start_s) begin
                        // Early sof: keep the word so the next frame can start with it.
                        err_s   = 1'b1;
                        state_d = ST_WAIT_FRAME;
                    end else begin
                        pop_s   = 1'b1;
                        drive_s = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_SYNC_SOF;
            end
        endcase
    end

    assign FIFO_RD_EN = pop_s & VID_CE & ~VID_RESET;

    // All state and the two-stage output pipeline advance only on enabled cycles.
    always_ff @(posedge VID_OUT_CLK or posedge VID_RESET) begin
        if (VID_RESET) begin
            state_q     <= ST_SYNC_SOF;
            de_q        <= 1'b0;
            vb_q        <= 1'b0;
            flag_q      <= 1'b0;
            s1_timing_q <= 6'd0;
            s1_data_q   <= 24'd0;
            s2_timing_q <= 6'd0;
            s2_data_q   <= 24'd0;
            locked_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else if (VID_CE) begin
            state_q     <= state_d;
            de_q        <= VTG_ACTIVE_VIDEO;
            vb_q        <= vb_s;
            flag_q      <= flag_d;
            s1_timing_q <= vtg_timing_s;
            s1_data_q   <= drive_s ? FIFO_RD_DATA[23:0] : 24'd0;
            s2_timing_q <= s1_timing_q;
            s2_data_q   <= s1_data_q;
            locked_q    <= (state_d == ST_RUN);
            underflow_q <= err_s;
        end else begin
            state_q     <= state_q;
            de_q        <= de_q;
            vb_q        <= vb_q;
            flag_q      <= flag_q;
            s1_timing_q <= s1_timing_q;
            s1_data_q   <= s1_data_q;
            s2_timing_q <= s2_timing_q;
            s2_data_q   <= s2_data_q;
            locked_q    <= locked_q;
            underflow_q <= underflow_q;
        end
    end

    assign VID_ACTIVE_VIDEO = s2_timing_q[5];
    assign VID_VBLANK       = s2_timing_q[4];
    assign VID_HBLANK       = s2_timing_q[3];
    assign VID_VSYNC        = s2_timing_q[2];
    assign VID_HSYNC        = s2_timing_q[1];
    assign VID_FIELD_ID     = s2_timing_q[0];
    assign VID_DATA         = s2_data_q;
    assign LOCKED           = locked_q;
    assign UNDERFLOW        = underflow_q;

endmodule

// File: tb/tb_axi4s_vid_out_formatter.sv
// Directed bench for axi4s_vid_out_formatter: a queue-backed FWFT FIFO and a tiny
// VTG sequencer drive the DUT; each scenario task checks its own expected values.
module tb_axi4s_vid_out_formatter;

    localparam logic [5:0] T_VS  = 6'b010100;
    localparam logic [5:0] T_VB  = 6'b010000;
    localparam logic [5:0] T_HS  = 6'b001010;
    localparam logic [5:0] T_HB  = 6'b001000;
    localparam logic [5:0] T_ACT = 6'b100000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b1;
    logic [26:0] rd_data = 27'd0;
    logic        empty = 1'b1;
    logic        rd_en;
    logic [5:0]  vtg = 6'd0;
    logic        vid_av, vid_vb, vid_hb, vid_vs, vid_hs, vid_fid;
    logic [23:0] vid_data;
    logic        locked;
    logic        uf_o;
    logic [5:0]  vid_t;
    logic [31:0] all_out;

    int vectors     = 0;
    int miscompares = 0;
    int pops        = 0;
    int uf_cnt      = 0;
    logic seen_active = 1'b0;
    logic lock_first  = 1'b0;
    logic ce_toggle   = 1'b0;

    logic [26:0] fifo_q[$];
    logic [23:0] out_q[$];
    logic [5:0]  in_q[$];
    logic [5:0]  obs_q[$];
    logic [31:0] pre_q[$];
    logic [31:0] post_q[$];
    logic        rd_low_q[$];

    assign vid_t   = {vid_av, vid_vb, vid_hb, vid_vs, vid_hs, vid_fid};
    assign all_out = {vid_t, vid_data, locked, uf_o};

    always #5 clk = ~clk;

    axi4s_vid_out_formatter dut (
        .VID_OUT_CLK      (clk),
        .VID_RESET        (rst),
        .VID_CE           (ce),
        .FIFO_RD_DATA     (rd_data),
        .FIFO_EMPTY       (empty),
        .FIFO_RD_EN       (rd_en),
        .VTG_ACTIVE_VIDEO (vtg[5]),
        .VTG_VBLANK       (vtg[4]),
        .VTG_HBLANK       (vtg[3]),
        .VTG_VSYNC        (vtg[2]),
        .VTG_HSYNC        (vtg[1]),
        .VTG_FIELD_ID     (vtg[0]),
        .VID_ACTIVE_VIDEO (vid_av),
        .VID_VBLANK       (vid_vb),
        .VID_HBLANK       (vid_hb),
        .VID_VSYNC        (vid_vs),
        .VID_HSYNC        (vid_hs),
        .VID_FIELD_ID     (vid_fid),
        .VID_DATA         (vid_data),
        .LOCKED           (locked),
        .UNDERFLOW        (uf_o)
    );

    function automatic logic [26:0] w(input logic sof, input logic eol, input logic [23:0] d);
        return {1'b0, sof, eol, d};
    endfunction

    task automatic upd_fifo();
        empty   = (fifo_q.size() == 0);
        rd_data = empty ? 27'd0 : fifo_q[0];
    endtask

    task automatic clear_logs();
        out_q.delete(); in_q.delete(); obs_q.delete();
        pre_q.delete(); post_q.delete(); rd_low_q.delete();
        pops = 0; uf_cnt = 0; seen_active = 1'b0; lock_first = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; vtg = 6'd0; ce = 1'b1;
        fifo_q.delete(); upd_fifo();
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic fill_frame(input logic [23:0] base, input int lines, input int pix);
        for (int i = 0; i < lines * pix; i++)
            fifo_q.push_back(w(i == 0, (i % pix) == pix - 1, base + 24'(i)));
    endtask

    // One enabled clock (optionally followed by one disabled clock), driven from negedge.
    task automatic step(input logic [5:0] t);
        logic rd;
        logic [31:0] pre;
        vtg = t; ce = 1'b1; upd_fifo();
        #1 rd = rd_en;
        @(posedge clk);
        if (rd) begin
            fifo_q.delete(0);
            pops++;
        end
        @(negedge clk);
        in_q.push_back(t);
        obs_q.push_back(vid_t);
        if (vid_av) begin
            out_q.push_back(vid_data);
            if (!seen_active) begin
                seen_active = 1'b1;
                lock_first  = locked;
            end
        end
        if (uf_o) uf_cnt++;
        if (ce_toggle) begin
            pre = all_out;
            ce  = 1'b0; upd_fifo();
            #1 rd_low_q.push_back(rd_en);
            @(posedge clk); @(negedge clk);
            pre_q.push_back(pre);
            post_q.push_back(all_out);
            ce = 1'b1;
        end
    endtask

    task automatic frame(input int lines, input int pix, input logic fid);
        step(T_VS | {5'd0, fid}); step(T_VB | {5'd0, fid});
        step(T_VB | {5'd0, fid}); step(T_VB | {5'd0, fid});
        for (int l = 0; l < lines; l++) begin
            step(T_HS | {5'd0, fid});
            for (int p = 0; p < pix; p++) step(T_ACT | {5'd0, fid});
            step(T_HB | {5'd0, fid});
        end
    endtask

    task automatic test_reset();
        vtg = T_ACT; ce = 1'b1;
        fifo_q.push_back(w(1'b0, 1'b0, 24'hDEAD01)); upd_fifo();
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (all_out !== 32'd0) begin miscompares++; $display("FAIL reset_outputs: got %h expected %h", all_out, 32'd0); end
        vectors++;
        if (rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        @(posedge clk); @(negedge clk);
        vectors++;
        if (all_out !== 32'd0) begin miscompares++; $display("FAIL reset_hold_outputs: got %h expected %h", all_out, 32'd0); end
        vectors++;
        if (rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_hold_rd_en: got %b expected 0", rd_en); end
        rst = 1'b0;
    endtask

    task automatic test_clean_lock();
        logic [23:0] got;
        logic [5:0]  exp_t;
        do_reset();
        fill_frame(24'h100000, 2, 4);
        frame(2, 4, 1'b0);
        vectors++;
        if (out_q.size() != 8) begin miscompares++; $display("FAIL lock_count: got %0d expected 8", out_q.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 24'hFFFFFF;
            vectors++;
            if (got !== 24'h100000 + 24'(i)) begin miscompares++; $display("FAIL lock_pix%0d: got %h expected %h", i, got, 24'h100000 + 24'(i)); end
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            exp_t = (i == 0) ? 6'd0 : in_q[i-1];
            vectors++;
            if (obs_q[i] !== exp_t) begin miscompares++; $display("FAIL lock_timing%0d: got %b expected %b", i, obs_q[i], exp_t); end
        end
        vectors++;
        if (lock_first !== 1'b1) begin miscompares++; $display("FAIL lock_first_pixel: got %b expected 1", lock_first); end
        vectors++;
        if (pops != 8) begin miscompares++; $display("FAIL lock_pops: got %0d expected 8", pops); end
        vectors++;
        if (uf_cnt != 0) begin miscompares++; $display("FAIL lock_underflow: got %0d expected 0", uf_cnt); end
    endtask

    task automatic test_garbage_purge();
        logic [23:0] got;
        do_reset();
        for (int i = 0; i < 3; i++) fifo_q.push_back(w(1'b0, 1'b0, 24'hBAD000 + 24'(i)));
        fill_frame(24'h200000, 2, 4);
        frame(2, 4, 1'b0);
        vectors++;
        if (pops != 11) begin miscompares++; $display("FAIL purge_pops: got %0d expected 11", pops); end
        for (int i = 0; i < 8; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 24'hFFFFFF;
            vectors++;
            if (got !== 24'h200000 + 24'(i)) begin miscompares++; $display("FAIL purge_pix%0d: got %h expected %h", i, got, 24'h200000 + 24'(i)); end
        end
        vectors++;
        if (locked !== 1'b1 || uf_cnt != 0) begin miscompares++; $display("FAIL purge_status: got locked=%b uf=%0d expected locked=1 uf=0", locked, uf_cnt); end
    endtask

    task automatic test_starvation();
        logic [23:0] got;
        logic [23:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) fifo_q.push_back(w(i == 0, 1'b0, 24'h300000 + 24'(i)));
        frame(1, 8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 24'hFFFFFF;
            exp = (i < 5) ? 24'h300000 + 24'(i) : 24'd0;
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL starve_pix%0d: got %h expected %h", i, got, exp); end
        end
        vectors++;
        if (uf_cnt != 1) begin miscompares++; $display("FAIL starve_underflow: got %0d expected 1", uf_cnt); end
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL starve_locked: got %b expected 0", locked); end
        clear_logs();
        fill_frame(24'h310000, 1, 8);
        frame(1, 8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 24'hFFFFFF;
            vectors++;
            if (got !== 24'h310000 + 24'(i)) begin miscompares++; $display("FAIL relock_pix%0d: got %h expected %h", i, got, 24'h310000 + 24'(i)); end
        end
        vectors++;
        if (locked !== 1'b1 || uf_cnt != 0) begin miscompares++; $display("FAIL relock_status: got locked=%b uf=%0d expected locked=1 uf=0", locked, uf_cnt); end
    endtask

    task automatic test_early_sof();
        logic [23:0] got;
        logic [23:0] exp;
        do_reset();
        fifo_q.push_back(w(1'b1, 1'b0, 24'h400000));
        fifo_q.push_back(w(1'b0, 1'b0, 24'h400001));
        fifo_q.push_back(w(1'b0, 1'b0, 24'h400002));
        fill_frame(24'h410000, 1, 8);
        frame(1, 8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 24'hFFFFFF;
            exp = (i < 3) ? 24'h400000 + 24'(i) : 24'd0;
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL early_pix%0d: got %h expected %h", i, got, exp); end
        end
        vectors++;
        if (pops != 3 || uf_cnt != 1) begin miscompares++; $display("FAIL early_pops_uf: got pops=%0d uf=%0d expected pops=3 uf=1", pops, uf_cnt); end
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL early_locked: got %b expected 0", locked); end
        clear_logs();
        frame(1, 8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 24'hFFFFFF;
            vectors++;
            if (got !== 24'h410000 + 24'(i)) begin miscompares++; $display("FAIL early_relock_pix%0d: got %h expected %h", i, got, 24'h410000 + 24'(i)); end
        end
        vectors++;
        if (locked !== 1'b1 || pops != 8) begin miscompares++; $display("FAIL early_relock: got locked=%b pops=%0d expected locked=1 pops=8", locked, pops); end
    endtask

    task automatic test_ce_gating();
        logic [23:0] got;
        logic [5:0]  exp_t;
        do_reset();
        fill_frame(24'h500000, 2, 4);
        ce_toggle = 1'b1;
        frame(2, 4, 1'b1);
        ce_toggle = 1'b0;
        vectors++;
        if (pops != 8) begin miscompares++; $display("FAIL ce_pops: got %0d expected 8", pops); end
        for (int i = 0; i < 8; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 24'hFFFFFF;
            vectors++;
            if (got !== 24'h500000 + 24'(i)) begin miscompares++; $display("FAIL ce_pix%0d: got %h expected %h", i, got, 24'h500000 + 24'(i)); end
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            exp_t = (i == 0) ? 6'd0 : in_q[i-1];
            vectors++;
            if (obs_q[i] !== exp_t) begin miscompares++; $display("FAIL ce_timing%0d: got %b expected %b", i, obs_q[i], exp_t); end
        end
        for (int i = 0; i < pre_q.size(); i++) begin
            vectors++;
            if (post_q[i] !== pre_q[i]) begin miscompares++; $display("FAIL ce_hold%0d: got %h expected %h", i, post_q[i], pre_q[i]); end
            vectors++;
            if (rd_low_q[i] !== 1'b0) begin miscompares++; $display("FAIL ce_rd_low%0d: got %b expected 0", i, rd_low_q[i]); end
        end
        vectors++;
        if (locked !== 1'b1 || uf_cnt != 0) begin miscompares++; $display("FAIL ce_status: got locked=%b uf=%0d expected locked=1 uf=0", locked, uf_cnt); end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] got;
        logic [23:0] exp;
        do_reset();
        fill_frame(24'h600000, 2, 4);
        step(T_VS); step(T_VB); step(T_VB); step(T_VB);
        step(T_HS); step(T_ACT); step(T_ACT);
        vectors++;
        if (pops != 2) begin miscompares++; $display("FAIL midrst_prepops: got %0d expected 2", pops); end
        vtg = T_ACT; upd_fifo();
        rst = 1'b1;
        #1;
        vectors++;
        if (all_out !== 32'd0) begin miscompares++; $display("FAIL midrst_outputs: got %h expected %h", all_out, 32'd0); end
        vectors++;
        if (rd_en !== 1'b0) begin miscompares++; $display("FAIL midrst_rd_en: got %b expected 0", rd_en); end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        clear_logs();
        step(T_ACT); step(T_ACT); step(T_HB);
        fill_frame(24'h610000, 2, 4);
        frame(2, 4, 1'b0);
        vectors++;
        if (pops != 14) begin miscompares++; $display("FAIL midrst_pops: got %0d expected 14", pops); end
        vectors++;
        if (out_q.size() != 10) begin miscompares++; $display("FAIL midrst_count: got %0d expected 10", out_q.size()); end
        for (int i = 0; i < 10; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 24'hFFFFFF;
            exp = (i < 2) ? 24'd0 : 24'h610000 + 24'(i - 2);
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL midrst_pix%0d: got %h expected %h", i, got, exp); end
        end
        vectors++;
        if (locked !== 1'b1 || uf_cnt != 0) begin miscompares++; $display("FAIL midrst_status: got locked=%b uf=%0d expected locked=1 uf=0", locked, uf_cnt); end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_garbage_purge();
        test_starvation();
        test_early_sof();
        test_ce_gating();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
